ofdm_demodulation: RTL and testbench

- Hard-decision QAM demapper. It is the receive-side counterpart of the OFDM symbol mapper.
- Accepts one equalised I/Q sample per handshake and slices it to the nearest constellation point for the selected modulation (BPSK, QPSK, QAM16, QAM64, QAM256).
- Packs the recovered bits LSB-first into bytes and emits them on a valid/ready byte stream toward the MAC/descrambler side.

---
 rtl/ofdm_demodulation_pkg.sv | 27 ++
 rtl/ofdm_demodulation_if.sv | 20 ++
 rtl/ofdm_demodulation_qam_axis_slicer.sv | 31 +++
 rtl/ofdm_demodulation.sv | 68 ++++++
 tb/tb_ofdm_demodulation.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/ofdm_demodulation_pkg.sv
// ofdm_demodulation_pkg: modulation codes, per-mode unit amplitudes and bit/level lookups
package ofdm_demodulation_pkg;
  localparam logic [2:0] BPSK_MOD   = 3'd0;
  localparam logic [2:0] QPSK_MOD   = 3'd1;
  localparam logic [2:0] QAM16_MOD  = 3'd2;
  localparam logic [2:0] QAM64_MOD  = 3'd3;
  localparam logic [2:0] QAM256_MOD = 3'd4;
  localparam int BPSK_UNIT   = 8192;
  localparam int QPSK_UNIT   = 8192;
  localparam int QAM16_UNIT  = 4096;
  localparam int QAM64_UNIT  = 2048;
  localparam int QAM256_UNIT = 1024;
  function automatic logic [3:0] bps(input logic [2:0] m);
    return m == BPSK_MOD ? 4'd1 : m == QPSK_MOD ? 4'd2 : m == QAM16_MOD ? 4'd4 :
           m == QAM64_MOD ? 4'd6 : m == QAM256_MOD ? 4'd8 : 4'd0;
  endfunction
  // decision spacing is 2*unit, so slicing is an arithmetic shift by log2(2*unit)
  function automatic logic [3:0] axis_shift(input logic [2:0] m);
    return m == QAM16_MOD ? 4'($clog2(QAM16_UNIT) + 1) :
           m == QAM64_MOD ? 4'($clog2(QAM64_UNIT) + 1) :
           m == QAM256_MOD ? 4'($clog2(QAM256_UNIT) + 1) :
           m == QPSK_MOD ? 4'($clog2(QPSK_UNIT) + 1) : 4'($clog2(BPSK_UNIT) + 1);
  endfunction
  function automatic logic [4:0] axis_levels(input logic [2:0] m);
    return m == QAM16_MOD ? 5'd4 : m == QAM64_MOD ? 5'd8 : m == QAM256_MOD ? 5'd16 : 5'd2;
  endfunction
endpackage

// File: rtl/ofdm_demodulation_if.sv
// ofdm_demodulation_if: symbol input and byte output handshake bundle
interface ofdm_demodulation_if #(parameter int DATA_SIZE = 16);
  logic                        i_valid;
  logic [2:0]                  i_modulation;
  logic signed [DATA_SIZE-1:0] i_data_i;
  logic signed [DATA_SIZE-1:0] i_data_q;
  logic                        o_wayt_res_data;
  logic                        i_flush;
  logic                        o_valid_data;
  logic                        i_wayt_data;
  logic [7:0]                  o_data;
  modport master (
    output i_valid, i_modulation, i_data_i, i_data_q, i_flush, i_wayt_data,
    input  o_wayt_res_data, o_valid_data, o_data
  );
  modport slave (
    input  i_valid, i_modulation, i_data_i, i_data_q, i_flush, i_wayt_data,
    output o_wayt_res_data, o_valid_data, o_data
  );
endinterface

// File: rtl/ofdm_demodulation_qam_axis_slicer.sv
// qam_axis_slicer: nearest-level decision on one axis, returned as the per-axis Gray code
module qam_axis_slicer
  import ofdm_demodulation_pkg::*;
#(
  parameter int DATA_SIZE = 16
) (
  input  logic signed [DATA_SIZE-1:0] value,
  input  logic [2:0]                  modulation,
  output logic [3:0]                  code
);
  localparam logic [63:0] GRAY256 = {4'd9, 4'd13, 4'd15, 4'd11, 4'd10, 4'd14, 4'd12, 4'd8,
                                     4'd0, 4'd4, 4'd6, 4'd2, 4'd3, 4'd7, 4'd5, 4'd1};
  localparam logic [23:0] GRAY64  = {3'd5, 3'd7, 3'd6, 3'd4, 3'd0, 3'd2, 3'd3, 3'd1};
  localparam logic [7:0]  GRAY16  = {2'd3, 2'd2, 2'd0, 2'd1};
  logic [4:0]                lv;
  logic signed [DATA_SIZE:0] v_ext, half, lim, pos;
  logic [3:0]                idx;
  // floor(v / 2A) + M/2 gives the level index with boundary values going up; clamp saturates
  always_comb begin
    lv    = axis_levels(modulation);
    v_ext = {value[DATA_SIZE-1], value};
    half  = {{(DATA_SIZE-3){1'b0}}, lv[4:1]};
    lim   = {{(DATA_SIZE-4){1'b0}}, lv - 5'd1};
    pos   = (v_ext >>> axis_shift(modulation)) + half;
    idx   = pos[DATA_SIZE] ? 4'd0 : pos > lim ? lim[3:0] : pos[3:0];
    code  = modulation == QAM256_MOD ? GRAY256[{idx, 2'b00} +: 4] :
            modulation == QAM64_MOD  ? {1'b0, GRAY64[5'(idx[2:0]) * 5'd3 +: 3]} :
            modulation == QAM16_MOD  ? {2'b00, GRAY16[{idx[1:0], 1'b0} +: 2]} :
            {3'b000, idx[0]};
  end
endmodule

// File: rtl/ofdm_demodulation.sv
// ofdm_demodulation: hard-decision QAM demapper packing bits LSB-first into a byte stream
// Optional DEMOD_MOD_ERR_EN adds a sticky o_mod_err flag for symbols with an invalid mode.
module ofdm_demodulation
  import ofdm_demodulation_pkg::*;
#(
  parameter int DATA_SIZE = 16
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  ofdm_demodulation_if.slave bus
`ifdef DEMOD_MOD_ERR_EN
  ,
  output logic               o_mod_err
`endif
);
  logic [15:0] acc, placed;
  logic [4:0]  count, base;
  logic        flush_pending, accept, slot_free, pop, flush_emit;
  logic [3:0]  code_i, code_q, nbits;
  logic [7:0]  sym;
  qam_axis_slicer #(.DATA_SIZE(DATA_SIZE)) u_slice_i (
    .value(bus.i_data_i), .modulation(bus.i_modulation), .code(code_i)
  );
  qam_axis_slicer #(.DATA_SIZE(DATA_SIZE)) u_slice_q (
    .value(bus.i_data_q), .modulation(bus.i_modulation), .code(code_q)
  );
  // ready depends only on registered state and the offered mode, never on downstream ready
  always_comb begin
    nbits               = bps(bus.i_modulation);
    bus.o_wayt_res_data = !flush_pending && (count + {1'b0, nbits} <= 5'd16);
    accept              = bus.i_valid && bus.o_wayt_res_data;
    slot_free           = !bus.o_valid_data || bus.i_wayt_data;
    pop                 = count >= 5'd8 && slot_free;
    flush_emit          = flush_pending && count != 5'd0 && count < 5'd8 && slot_free;
    sym                 = nbits == 4'd0 ? 8'd0 :
                          nbits == 4'd1 ? {7'd0, code_i[0]} :
                          ({4'd0, code_q} << nbits[3:1]) | {4'd0, code_i};
    base                = count - (pop ? 5'd8 : 5'd0);
    placed              = {8'd0, sym} << base;
  end
  // accumulator, byte output slot and flush drain state
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      acc              <= '0;
      count            <= '0;
      flush_pending    <= 1'b0;
      bus.o_valid_data <= 1'b0;
      bus.o_data       <= '0;
    end else begin
      flush_pending <= bus.i_flush || (flush_pending && count != 5'd0);
      acc           <= flush_emit ? 16'd0 : (pop ? acc >> 8 : acc) | (accept ? placed : 16'd0);
      count         <= flush_emit ? 5'd0 : base + (accept ? {1'b0, nbits} : 5'd0);
      if (pop || flush_emit) begin
        bus.o_valid_data <= 1'b1;
        bus.o_data       <= pop ? acc[7:0] : acc[7:0] & ~(8'hFF << count[2:0]);
      end else if (bus.i_wayt_data) begin
        bus.o_valid_data <= 1'b0;
      end
    end
  end
`ifdef DEMOD_MOD_ERR_EN
  // sticky flag for any consumed symbol carrying an undefined modulation code
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) o_mod_err <= 1'b0;
    else if (accept && bus.i_modulation > QAM256_MOD) o_mod_err <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_ofdm_demodulation.sv
// tb_ofdm_demodulation: directed checks of slicing, packing, backpressure, flush and reset
module tb_ofdm_demodulation;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_acc = 0;
  logic [7:0] got[$];
  ofdm_demodulation_if #(.DATA_SIZE(16)) bus ();
`ifdef DEMOD_MOD_ERR_EN
  logic mod_err;
`endif
  ofdm_demodulation #(.DATA_SIZE(16)) dut (
    .i_clk(clk),
    .i_reset_n(rst_n),
    .bus(bus.slave)
`ifdef DEMOD_MOD_ERR_EN
    ,
    .o_mod_err(mod_err)
`endif
  );
  always #5 clk = ~clk;
  // inputs change only just after posedge, so negedge sees what the next edge will see
  always @(negedge clk) begin
    if (bus.o_valid_data && bus.i_wayt_data) got.push_back(bus.o_data);
    if (bus.i_valid && bus.o_wayt_res_data) n_acc++;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send(input logic [2:0] m, input logic signed [15:0] di, input logic signed [15:0] dq);
    bus.i_modulation = m;
    bus.i_data_i     = di;
    bus.i_data_q     = dq;
    bus.i_valid      = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.o_wayt_res_data) begin
        step(1);
        bus.i_valid = 1'b0;
        return;
      end
      step(1);
    end
    bus.i_valid = 1'b0;
    n_checks++;
    n_fail++;
    $error("FAIL send_timeout: observed ready=0 expected ready=1 within 40 cycles");
  endtask
  task automatic expect_byte(input string tag, input logic [7:0] exp);
    for (int k = 0; k < 40 && got.size() == 0; k++) begin
      @(negedge clk);
      #1;
    end
    if (got.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL %s: observed no byte expected %0h", tag, exp);
    end else check(tag, got.pop_front(), exp);
    step(1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.i_valid = 1'b0;
    bus.i_modulation = 3'd4;
    bus.i_data_i = '0;
    bus.i_data_q = '0;
    bus.i_flush = 1'b0;
    bus.i_wayt_data = 1'b1;
    step(2);
    @(negedge clk);
    check("reset_valid", bus.o_valid_data, 0);
    check("reset_data", bus.o_data, 0);
    check("reset_ready", bus.o_wayt_res_data, 1);
    step(1);
    rst_n = 1'b1;
    step(1);
    send(3'd4, 16'sd1024, -16'sd15360);
    @(negedge clk);
    check("t1_valid_early", bus.o_valid_data, 0);
    check("t1_ready", bus.o_wayt_res_data, 1);
    step(1);
    @(negedge clk);
    check("t1_valid", bus.o_valid_data, 1);
    check("t1_data", bus.o_data, 8'h18);
    check("t1_ready_hold", bus.o_wayt_res_data, 1);
    step(1);
    got.delete();
    @(negedge clk);
    check("t1_drained", bus.o_valid_data, 0);
    step(1);
    send(3'd1, 16'sd8192, -16'sd8192);
    send(3'd1, 16'sd8192, 16'sd8192);
    send(3'd1, -16'sd8192, -16'sd8192);
    send(3'd1, -16'sd8192, 16'sd8192);
    expect_byte("qpsk_byte", 8'h8D);
    for (int s = 0; s < 4; s++) send(3'd3, 16'sd14336, -16'sd14336);
    expect_byte("qam64_b0", 8'h4D);
    expect_byte("qam64_b1", 8'hD3);
    expect_byte("qam64_b2", 8'h34);
    send(3'd2, 16'sd0, 16'sd0);
    send(3'd2, 16'sd8192, -16'sd32768);
    send(3'd2, -16'sd32768, 16'sd8192);
    send(3'd2, -16'sd4096, 16'sd4095);
    expect_byte("qam16_b0", 8'h7A);
    expect_byte("qam16_b1", 8'h8D);
    send(3'd5, 16'sd8192, 16'sd8192);
    step(3);
    check("invalid_no_byte", got.size(), 0);
    bus.i_wayt_data = 1'b0;
    n_acc = 0;
    send(3'd4, 16'sd1024, -16'sd15360);
    send(3'd4, -16'sd1024, 16'sd15360);
    send(3'd4, 16'sd0, 16'sd0);
    @(negedge clk);
    check("bp_valid", bus.o_valid_data, 1);
    check("bp_data", bus.o_data, 8'h18);
    check("bp_accepts", n_acc, 3);
    step(1);
    bus.i_modulation = 3'd4;
    bus.i_valid = 1'b1;
    step(4);
    @(negedge clk);
    check("bp_ready_low", bus.o_wayt_res_data, 0);
    check("bp_accepts_held", n_acc, 3);
    check("bp_data_stable", bus.o_data, 8'h18);
    step(1);
    bus.i_valid = 1'b0;
    bus.i_wayt_data = 1'b1;
    send(3'd4, -16'sd16384, 16'sd3072);
    expect_byte("bp_b0", 8'h18);
    expect_byte("bp_b1", 8'h90);
    expect_byte("bp_b2", 8'h88);
    expect_byte("bp_b3", 8'hC1);
    send(3'd0, 16'sd8192, -16'sd8192);
    send(3'd0, -16'sd8192, 16'sd8192);
    send(3'd0, 16'sd8192, 16'sd8192);
    bus.i_flush = 1'b1;
    step(1);
    bus.i_flush = 1'b0;
    @(negedge clk);
    check("flush_blocks_ready", bus.o_wayt_res_data, 0);
    step(1);
    expect_byte("flush_byte", 8'h05);
    bus.i_flush = 1'b1;
    step(1);
    bus.i_flush = 1'b0;
    step(5);
    check("flush_empty_nothing", got.size(), 0);
    @(negedge clk);
    check("flush_ready_back", bus.o_wayt_res_data, 1);
    step(1);
    bus.i_wayt_data = 1'b0;
    send(3'd3, 16'sd14336, -16'sd14336);
    send(3'd3, 16'sd14336, -16'sd14336);
    step(2);
    @(negedge clk);
    check("rst_valid_before", bus.o_valid_data, 1);
    step(1);
    rst_n = 1'b0;
    #1;
    check("rst_valid_async", bus.o_valid_data, 0);
    check("rst_data_async", bus.o_data, 0);
    step(2);
    rst_n = 1'b1;
    bus.i_wayt_data = 1'b1;
    step(4);
    check("rst_no_residual", got.size(), 0);
    send(3'd1, 16'sd8192, -16'sd8192);
    send(3'd1, 16'sd8192, 16'sd8192);
    send(3'd1, -16'sd8192, -16'sd8192);
    send(3'd1, -16'sd8192, 16'sd8192);
    expect_byte("rst_clean_byte", 8'h8D);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
